// File: rtl/sound_pkg.sv
// Shared definitions for the sound output path: FSM encoding, limits and
// cycle-count helpers used by beep_player and tone_div.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned MAX_BEEPS = 3;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                              input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Counters run 0..n-1, so $clog2(n) bits suffice; a 1-cycle period still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beep_player_tone_div.sv
// Square-wave divider: sq toggles every HALF cycles while run is high,
// restarts high on the first cycle after run rises, and is 0 otherwise.
module tone_div
    import sound_pkg::*;
#(
    parameter int unsigned HALF = 5
) (
    input  logic CLK,
    input  logic ena,
    input  logic run,
    output logic sq
);

    localparam int unsigned W = cnt_width(HALF);
    localparam logic [W-1:0] HALF_LAST = W'(HALF - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sq_q, sq_d;
    logic         run_q;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (!run) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (!run_q) begin
            cnt_d = '0;
            sq_d  = 1'b1;
        end else if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            sq_d  = ~sq_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ena) begin
        if (!ena) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
            run_q <= run;
        end
    end

    assign sq = sq_q;

endmodule

// File: rtl/beep_player.sv
// Piezo beep burst player: plays 0..3 tone bursts separated by silent gaps
// on a start strobe, with abort and completion pulse.
module beep_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TONE_HZ = 2_000,
    parameter int unsigned BEEP_MS = 150,
    parameter int unsigned GAP_MS  = 100
) (
    input  logic       CLK,
    input  logic       ena,
    input  logic       start,
    input  logic [1:0] count,
    input  logic       abort,
    output logic       buzz,
    output logic       busy,
    output logic       done,
    output logic [1:0] beep_idx
);

    localparam int unsigned HALF     = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned BEEP_CYC = ms_to_cyc(CLK_HZ, BEEP_MS);
    localparam int unsigned GAP_CYC  = ms_to_cyc(CLK_HZ, GAP_MS);
    localparam int unsigned MAX_BG   = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC  = (HALF > MAX_BG) ? HALF : MAX_BG;
    localparam int unsigned W        = cnt_width(MAX_CYC);
    localparam int unsigned RW       = $clog2(MAX_BEEPS + 1);

    localparam logic [W-1:0] BEEP_LAST = W'(BEEP_CYC - 1);
    localparam logic [W-1:0] GAP_LAST  = W'(GAP_CYC - 1);

    if (HALF == 0 || BEEP_CYC == 0 || GAP_CYC == 0) begin : g_bad_params
        $error("beep_player: HALF, BEEP_CYC and GAP_CYC must all be >= 1");
    end

    state_t          state_q, state_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [W-1:0]    phase_q, phase_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      idx_q, idx_d;
    logic            tone_run;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                idx_d  = 2'd0;
                if (start && !abort) begin
                    if (count != 2'd0) begin
                        state_d = TONE;
                        rem_d   = RW'(count);
                        phase_d = '0;
                        busy_d  = 1'b1;
                        idx_d   = 2'd1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            TONE: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    idx_d   = 2'd0;
                end else if (phase_q == BEEP_LAST) begin
                    phase_d = '0;
                    if (rem_q > RW'(1)) begin
                        state_d = GAP;
                        rem_d   = rem_q - 1'b1;
                    end else begin
                        // beep_idx holds through the done cycle and clears from IDLE
                        state_d = IDLE;
                        rem_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    idx_d   = 2'd0;
                end else if (phase_q == GAP_LAST) begin
                    state_d = TONE;
                    phase_d = '0;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
                phase_d = '0;
                busy_d  = 1'b0;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ena) begin
        if (!ena) begin
            state_q <= IDLE;
            rem_q   <= '0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    // Divider is driven by the next state so its registered sq lines up with state_q.
    assign tone_run = (state_d == TONE);

    tone_div #(
        .HALF (HALF)
    ) u_tone_div (
        .CLK (CLK),
        .ena (ena),
        .run (tone_run),
        .sq  (buzz)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign beep_idx = idx_q;

endmodule

// File: tb/tb_beep_player.sv
// Self-checking bench for beep_player using small sim parameters and a
// cycle-indexed arithmetic model of the expected burst waveform.
module tb_beep_player;

    localparam int unsigned CLK_HZ  = 10_000;
    localparam int unsigned TONE_HZ = 1_000;
    localparam int unsigned BEEP_MS = 2;
    localparam int unsigned GAP_MS  = 1;
    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int B    = (CLK_HZ / 1000) * BEEP_MS;
    localparam int G    = (CLK_HZ / 1000) * GAP_MS;

    typedef struct packed {
        logic       buzz;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } obs_t;

    logic       CLK = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic [1:0] count = 2'd0;
    logic       abort = 1'b0;
    logic       buzz, busy, done;
    logic [1:0] beep_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    beep_player #(
        .CLK_HZ  (CLK_HZ),
        .TONE_HZ (TONE_HZ),
        .BEEP_MS (BEEP_MS),
        .GAP_MS  (GAP_MS)
    ) dut (
        .CLK      (CLK),
        .ena      (ena),
        .start    (start),
        .count    (count),
        .abort    (abort),
        .buzz     (buzz),
        .busy     (busy),
        .done     (done),
        .beep_idx (beep_idx)
    );

    function automatic int burst_len(input int n);
        return (n == 0) ? 0 : n * B + (n - 1) * G;
    endfunction

    // Expected outputs k cycles after the start strobe (cycle 0 = strobe cycle).
    function automatic obs_t model(input int n, input int k, input int abort_at);
        obs_t o;
        int   L, j;
        o = '0;
        L = burst_len(n);
        if (abort_at > 0 && k > abort_at) return o;
        if (n == 0) begin
            o.done = (k == 1);
            return o;
        end
        if (k >= 1 && k <= L) begin
            j      = (k - 1) % (B + G);
            o.busy = 1'b1;
            o.idx  = 2'((k - 1) / (B + G) + 1);
            if (j < B) o.buzz = ((j / HALF) % 2) == 0;
        end else if (k == L + 1) begin
            o.done = 1'b1;
            o.idx  = 2'(n);
        end
        return o;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_burst(input string name, input int n, input int abort_at,
                             input int dup_at, input int dup_cnt, input int last_k);
        obs_t got, exp;
        start = 1'b1;
        count = 2'(n);
        abort = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            tick;
            got = {buzz, busy, done, beep_idx};
            exp = model(n, k, abort_at);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s k=%0d got buzz=%b busy=%b done=%b idx=%0d, expected buzz=%b busy=%b done=%b idx=%0d",
                         name, k, got.buzz, got.busy, got.done, got.idx,
                         exp.buzz, exp.busy, exp.done, exp.idx);
            end
            start = (k == dup_at);
            count = (k == dup_at) ? 2'(dup_cnt) : 2'($urandom);
            abort = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        obs_t got;
        start = 1'b1;
        count = 2'd3;
        tick;
        tick;
        got = {buzz, busy, done, beep_idx};
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_hold got %b expected 00000", got);
        end
        start = 1'b0;
        ena   = 1'b1;
        tick;
        got = {buzz, busy, done, beep_idx};
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_release got %b expected 00000", got);
        end
    endtask

    task automatic test_single;
        run_burst("single", 1, 0, 0, 0, burst_len(1) + 3);
    endtask

    task automatic test_triple;
        run_burst("triple", 3, 0, 0, 0, burst_len(3) + 3);
    endtask

    task automatic test_zero;
        run_burst("zero", 0, 0, 0, 0, 4);
    endtask

    task automatic test_start_while_busy;
        run_burst("start_busy", 1, 0, 5, 2, burst_len(1) + 4);
    endtask

    task automatic test_abort;
        run_burst("abort_gap", 3, 25, 0, 0, 32);
    endtask

    task automatic test_abort_idle;
        obs_t got;
        start = 1'b1;
        count = 2'd2;
        abort = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            got = {buzz, busy, done, beep_idx};
            n_checks++;
            if (got !== obs_t'('0)) begin
                n_fail++;
                $display("FAIL abort_idle k=%0d got %b expected 00000", k, got);
            end
            start = 1'b0;
            abort = (k < 2);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_mid;
        obs_t got;
        run_burst("rst_mid", 1, 0, 0, 0, 12);
        #1 ena = 1'b0;
        #1;
        got = {buzz, busy, done, beep_idx};
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL rst_async got %b expected 00000", got);
        end
        tick;
        tick;
        ena = 1'b1;
        tick;
        got = {buzz, busy, done, beep_idx};
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL rst_after got %b expected 00000", got);
        end
        run_burst("after_rst", 1, 0, 0, 0, burst_len(1) + 3);
    endtask

    task automatic test_back_to_back;
        run_burst("b2b_first", 2, 0, 0, 0, burst_len(2) + 1);
        run_burst("b2b_second", 1, 0, 0, 0, burst_len(1) + 3);
    endtask

    task automatic test_random;
        int n, L, abort_at, dup_at;
        for (int i = 0; i < 10; i++) begin
            n        = int'($urandom_range(0, 3));
            L        = burst_len(n);
            abort_at = 0;
            dup_at   = 0;
            if (n > 0 && $urandom_range(0, 1) == 1) abort_at = int'($urandom_range(1, L));
            if (n > 0 && $urandom_range(0, 1) == 1)
                dup_at = int'($urandom_range(1, (abort_at > 0) ? abort_at : L));
            run_burst("random", n, abort_at, dup_at, int'($urandom_range(0, 3)), L + 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset;
        test_single;
        test_triple;
        test_zero;
        test_start_while_busy;
        test_abort;
        test_abort_idle;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
